// File: rtl/discr_scaler_ctrl.sv
// discr_scaler_ctrl: arms a shared discriminator scaler, applies config at
// period boundaries and windows its per-period counts into a 2-deep FIFO.
module discr_scaler_ctrl #(
   parameter int P_N_WIDTH    = 4,
   parameter int P_SUM_WIDTH  = 24,
   parameter int P_ACC_N      = 4,
   parameter int P_ARM_CYC    = 4,
   parameter int P_DEF_PERIOD = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     cfg_wr,
   input  logic [31:0]              cfg_period,
   input  logic [31:0]              cfg_inhibit,
   output logic                     scl_rst,
   output logic [31:0]              scl_period,
   output logic [31:0]              scl_inhibit_len,
   input  logic                     scl_valid,
   input  logic [P_N_WIDTH-1:0]     scl_n_pedge,
   input  logic                     scl_update,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [8+P_SUM_WIDTH-1:0] rd_data,
   output logic [15:0]              drop_cnt,
   output logic                     busy
);

   localparam int IW = (P_ACC_N > 1) ? $clog2(P_ACC_N) : 1;
   localparam int AW = (P_ARM_CYC > 1) ? $clog2(P_ARM_CYC) : 1;
   localparam int DW = 8 + P_SUM_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

   state_t                 state;
   logic [AW-1:0]          arm_cnt;
   logic [IW-1:0]          idx;
   logic [P_SUM_WIDTH-1:0] sum;
   logic [7:0]             seq;
   logic                   pend;
   logic [31:0]            pend_period;
   logic [31:0]            pend_inhibit;
   logic [DW-1:0]          tail;
   logic [1:0]             cnt;

   logic                   accept;
   logic                   pop;
   logic                   last;
   logic                   done;
   logic                   push;
   logic                   drop;
   logic                   leave;
   logic [P_SUM_WIDTH:0]   sum_add;
   logic [P_SUM_WIDTH-1:0] sum_sat;
   logic [DW-1:0]          win;
   logic [1:0]             cnt_nx;

   assign accept  = (state == S_RUN) & scl_update & scl_valid;
   assign leave   = (state == S_RUN) & ~enable;
   assign pop     = rd_valid & rd_ready;
   assign sum_add = {1'b0, sum} + (P_SUM_WIDTH+1)'(scl_n_pedge);
   assign sum_sat = sum_add[P_SUM_WIDTH] ? '1 : sum_add[P_SUM_WIDTH-1:0];
   assign last    = (idx == IW'(P_ACC_N-1));
   assign done    = accept & ~pend & last;
   // a full FIFO still takes the window if its head leaves this cycle
   assign push    = done & ((cnt != 2'd2) | pop);
   assign drop    = done & ~push;
   assign win     = {seq, sum_sat};
   assign cnt_nx  = cnt + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         arm_cnt <= '0;
         scl_rst <= 1'b1;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               arm_cnt <= '0;
               if (enable) begin
                  state <= S_ARM;
                  busy  <= 1'b1;
               end
            end
            S_ARM: begin
               if (!enable) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (arm_cnt == AW'(P_ARM_CYC-1)) begin
                  state   <= S_RUN;
                  scl_rst <= 1'b0;
               end else begin
                  arm_cnt <= arm_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  state   <= S_IDLE;
                  scl_rst <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               scl_rst <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_period      <= 32'(P_DEF_PERIOD);
         scl_inhibit_len <= '0;
         pend            <= 1'b0;
         pend_period     <= '0;
         pend_inhibit    <= '0;
         sum             <= '0;
         idx             <= '0;
         seq             <= '0;
         drop_cnt        <= '0;
      end else begin
         if (accept && pend) begin
            scl_period      <= pend_period;
            scl_inhibit_len <= pend_inhibit;
            pend            <= 1'b0;
         end
         if (cfg_wr) begin
            if (state == S_RUN) begin
               pend_period  <= cfg_period;
               pend_inhibit <= cfg_inhibit;
               pend         <= 1'b1;
            end else begin
               scl_period      <= cfg_period;
               scl_inhibit_len <= cfg_inhibit;
            end
         end
         if (leave || (accept && (pend || last))) begin
            sum <= '0;
            idx <= '0;
         end else if (accept) begin
            sum <= sum_sat;
            idx <= idx + 1'b1;
         end
         if (done)
            seq <= seq + 1'b1;
         if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         tail     <= '0;
         cnt      <= '0;
         rd_valid <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         rd_valid <= (cnt_nx != 2'd0);
         unique case (1'b1)
            (cnt == 2'd0): begin
               if (push)
                  rd_data <= win;
            end
            (cnt == 2'd1): begin
               if (push && pop)
                  rd_data <= win;
               else if (push)
                  tail <= win;
            end
            default: begin
               if (pop) begin
                  rd_data <= tail;
                  if (push)
                     tail <= win;
               end
            end
         endcase
      end
   end

endmodule
